// File: rtl/alu_3_pipe.sv
// alu_3_pipe: pipelined, back-pressured metadata-rewrite ALU (type 3) with output FIFO.
// Ports: clk, rst_n (sync, active-low), comp_meta_data_in/action_in/action_valid_in -> ready_out;
//   comp_meta_data_out/comp_meta_data_valid_out <- ready_in.
//   Optional stat_pkt_cnt/stat_discard_cnt when ALU_META_STATS_EN is defined.
module alu_3_pipe #(
    parameter int STAGE_ID   = 0,
    parameter int ACTION_LEN = 25,
    parameter int META_LEN   = 256,
    parameter int COMP_LEN   = 100,
    parameter int LATENCY    = 3,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [META_LEN+COMP_LEN-1:0] comp_meta_data_in,
    input  logic [ACTION_LEN-1:0]        action_in,
    input  logic                         action_valid_in,
    output logic                         ready_out,
    output logic [META_LEN+COMP_LEN-1:0] comp_meta_data_out,
    input  logic                         ready_in,
`ifdef ALU_META_STATS_EN
    output logic [31:0]                  stat_pkt_cnt,
    output logic [31:0]                  stat_discard_cnt,
`endif
    output logic                         comp_meta_data_valid_out
);

    localparam int W  = META_LEN + COMP_LEN;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam int unused_stage_id = STAGE_ID;

    logic [3:0]   op;
    logic [W-1:0] rw_d;
    logic         accept;
    logic         ready_q;

    assign op     = action_in[24:21];
    assign accept = action_valid_in && ready_q;

    logic unused_bits;
    assign unused_bits = ^{action_in[11], action_in[4:0]};

    always_comb begin
        rw_d = comp_meta_data_in;
        case (op)
            4'b1100: begin
                rw_d[W-1 -: 6] = action_in[10:5];
                rw_d[31:24]    = action_in[20:13];
            end
            4'b1101: begin
                rw_d[W-1 -: 6] = action_in[10:5];
                rw_d[128]      = action_in[12];
            end
            4'b1110: begin
                rw_d[W-1 -: 6] = action_in[10:5];
                rw_d[31:24]    = comp_meta_data_in[31:24] | action_in[20:13];
            end
            default: ;
        endcase
    end

    // Valid-tagged pipeline; only valids are reset.
    logic [LATENCY-1:0] pv_q;
    logic [W-1:0]       pd_q [LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) pv_q[i] <= pv_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pd_q[0] <= rw_d;
        for (int i = 1; i < LATENCY; i++) pd_q[i] <= pd_q[i-1];
    end

    // FWFT FIFO; the last stage bypasses storage when the FIFO is
    // empty so a result is visible the cycle it leaves the pipeline.
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   fcnt_q;
    logic          f_empty, last_v, valid_o, xfer, f_wr, f_rd;
    logic [W-1:0]  last_d, head;

    assign f_empty = (fcnt_q == '0);
    assign last_v  = pv_q[LATENCY-1];
    assign last_d  = pd_q[LATENCY-1];
    assign valid_o = !f_empty || last_v;
    assign head    = f_empty ? last_d : mem_q[rd_q];
    assign xfer    = valid_o && ready_in;
    assign f_wr    = last_v && !(f_empty && ready_in);
    assign f_rd    = !f_empty && ready_in;

    assign comp_meta_data_valid_out = valid_o;
    assign comp_meta_data_out       = valid_o ? head : '0;

    always_ff @(posedge clk) begin
        if (f_wr) mem_q[wr_q] <= last_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (f_wr) wr_q <= wr_q + 1'b1;
            if (f_rd) rd_q <= rd_q + 1'b1;
            case ({f_wr, f_rd})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Occupancy covers pipeline plus FIFO, so admission never overflows.
    logic [AW:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        case ({accept, xfer})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            ready_q <= (occ_d < DEPTH_C);
        end
    end

    assign ready_out = ready_q;

`ifdef ALU_META_STATS_EN
    logic [31:0] pkt_q, disc_q;
    logic        disc_hit;

    assign disc_hit = accept && (op == 4'b1101) && action_in[12];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_q  <= '0;
            disc_q <= '0;
        end else begin
            if (accept && (pkt_q != '1))    pkt_q  <= pkt_q + 1'b1;
            if (disc_hit && (disc_q != '1)) disc_q <= disc_q + 1'b1;
        end
    end

    assign stat_pkt_cnt     = pkt_q;
    assign stat_discard_cnt = disc_q;
`endif

endmodule
